// File: rtl/fcvt_arb.sv
// Two-requester arbiter sharing one double-to-int64 converter.
// Round-robin grant in IDLE, one conversion cycle, then hold until the consumer takes the result.

module FCVT_int (
    input  logic [63:0] fp,
    output logic [63:0] in
);
    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    logic        sign;
    logic [10:0] exp_f;
    logic [63:0] mag;

    // Truncate toward zero; NaN and out-of-range values saturate by sign (NaN treated as positive)
    always_comb begin
        sign  = fp[63];
        exp_f = fp[62:52];
        mag   = {11'b0, 1'b1, fp[51:0]};
        in    = '0;
        if (exp_f == 11'd2047) begin
            in = (sign && fp[51:0] == 52'd0) ? INT_MIN : INT_MAX;
        end else if (exp_f >= 11'd1086) begin
            in = sign ? INT_MIN : INT_MAX;
        end else if (exp_f >= 11'd1023) begin
            if (exp_f >= 11'd1075)
                mag = mag << (exp_f - 11'd1075);
            else
                mag = mag >> (11'd1075 - exp_f);
            in = sign ? (~mag + 64'd1) : mag;
        end
    end
endmodule

module fcvt_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [63:0]      req0_fp,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [63:0]      req1_fp,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [63:0]      rsp_int,
    output logic             rsp_nv,
    output logic             rsp_nx
);
    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t           state;
    logic             rr_ptr;
    logic             grant_id;
    logic             accept;
    logic [63:0]      op_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;
    logic [63:0]      conv_int;
    logic [10:0]      op_exp;
    logic [63:0]      frac_mask;
    logic             flag_nv;
    logic             flag_nx;

    // On a tie the requester not granted last wins; otherwise the sole valid one
    assign grant_id   = (req0_valid && req1_valid) ? ~rr_ptr : req1_valid;
    assign req0_ready = (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && req1_valid && grant_id;
    assign accept     = req0_ready || req1_ready;

    FCVT_int u_cvt (
        .fp (op_q),
        .in (conv_int)
    );

    // Only -2^63 is representable at the top exponent; everything else there overflows
    always_comb begin
        op_exp    = op_q[62:52];
        frac_mask = '0;
        flag_nv   = (op_exp == 11'd2047) ||
                    (op_exp >= 11'd1086 && op_q != 64'hC3E0_0000_0000_0000);
        flag_nx   = 1'b0;
        if (!flag_nv && op_q[62:0] != 63'd0) begin
            if (op_exp < 11'd1023) begin
                flag_nx = 1'b1;
            end else if (op_exp < 11'd1075) begin
                frac_mask = (64'd1 << (11'd1075 - op_exp)) - 64'd1;
                flag_nx   = (({12'b0, op_q[51:0]} & frac_mask) != 64'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b1;
            op_q      <= '0;
            tag_q     <= '0;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_tag   <= '0;
            rsp_int   <= '0;
            rsp_nv    <= 1'b0;
            rsp_nx    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= grant_id ? req1_fp : req0_fp;
                        tag_q  <= grant_id ? req1_tag : req0_tag;
                        id_q   <= grant_id;
                        rr_ptr <= grant_id;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    rsp_int   <= conv_int;
                    rsp_nv    <= flag_nv;
                    rsp_nx    <= flag_nx;
                    rsp_tag   <= tag_q;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fcvt_arb.sv
// Directed bench for fcvt_arb: conversion vector table plus round-robin, hold and reset sequences.

module tb_fcvt_arb;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [63:0]      req0_fp, req1_fp;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             req0_ready, req1_ready;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_nv, rsp_nx;
    logic [TAG_W-1:0] rsp_tag;
    logic [63:0]      rsp_int;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             id;
        logic [63:0]      fp;
        logic [TAG_W-1:0] tag;
        logic [63:0]      exp_int;
        logic             exp_nv;
        logic             exp_nx;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    fcvt_arb #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_fp    (req0_fp),
        .req0_tag   (req0_tag),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_fp    (req1_fp),
        .req1_tag   (req1_tag),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_int    (rsp_int),
        .rsp_nv     (rsp_nv),
        .rsp_nx     (rsp_nx)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction: accept, one conversion cycle, response, back to IDLE
    task automatic applyStimulus(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_fp = v.fp; req1_tag = v.tag;
        end else begin
            req0_valid = 1'b1; req0_fp = v.fp; req0_tag = v.tag;
        end
        #1;
        check({nm, "_ready"}, {62'd0, req1_ready, req0_ready}, v.id ? 64'd2 : 64'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_fp = '0; req1_fp = '0;
        check({nm, "_conv_valid"}, {63'd0, rsp_valid}, 64'd0);
        @(posedge clk);
        #1;
        checkOutput(nm, v);
        @(posedge clk);
        #1;
        check({nm, "_cleared"}, {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic checkOutput(input string nm, input vec_t v);
        check({nm, "_valid"}, {63'd0, rsp_valid}, 64'd1);
        check({nm, "_int"}, rsp_int, v.exp_int);
        check({nm, "_nv_nx"}, {62'd0, rsp_nv, rsp_nx}, {62'd0, v.exp_nv, v.exp_nx});
        check({nm, "_id_tag"}, {59'd0, rsp_id, rsp_tag}, {59'd0, v.id, v.tag});
    endtask

    initial begin
        vec_t  hv;
        int    got;
        int    cyc;
        logic  saw;
        logic [63:0] snap_int;
        logic [7:0]  snap_misc;

        vecs[0]  = '{1'b0, 64'h3FF0000000000000, 4'h3, 64'd1,                  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 64'hBFF8000000000000, 4'h5, 64'hFFFFFFFFFFFFFFFF,   1'b0, 1'b1};
        vecs[2]  = '{1'b0, 64'h47F0000000000000, 4'h7, 64'h7FFFFFFFFFFFFFFF,   1'b1, 1'b0};
        vecs[3]  = '{1'b1, 64'hC3E0000000000000, 4'h9, 64'h8000000000000000,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 64'h0000000000000000, 4'hA, 64'd0,                  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 64'h8000000000000000, 4'hB, 64'd0,                  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 64'h0000000000000001, 4'hC, 64'd0,                  1'b0, 1'b1};
        vecs[7]  = '{1'b1, 64'h3FE0000000000000, 4'hD, 64'd0,                  1'b0, 1'b1};
        vecs[8]  = '{1'b0, 64'h4059000000000000, 4'hE, 64'd100,                1'b0, 1'b0};
        vecs[9]  = '{1'b1, 64'hFFF0000000000000, 4'hF, 64'h8000000000000000,   1'b1, 1'b0};
        vecs[10] = '{1'b0, 64'h43E0000000000000, 4'h1, 64'h7FFFFFFFFFFFFFFF,   1'b1, 1'b0};
        vecs[11] = '{1'b1, 64'h43DFFFFFFFFFFFFF, 4'h2, 64'h7FFFFFFFFFFFFC00,   1'b0, 1'b0};
        vecs[12] = '{1'b0, 64'hC000000000000000, 4'h4, 64'hFFFFFFFFFFFFFFFE,   1'b0, 1'b0};
        vecs[13] = '{1'b1, 64'h4330000000000001, 4'h6, 64'h0010000000000001,   1'b0, 1'b0};
        vecs[14] = '{1'b0, 64'h432FFFFFFFFFFFFF, 4'h8, 64'h000FFFFFFFFFFFFF,   1'b0, 1'b1};

        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_fp = '0; req1_fp = '0; req0_tag = '0; req1_tag = '0;
        rsp_ready = 1'b0;
        do_reset();

        #1;
        check("reset_rsp", {rsp_int[31:0], 24'd0, rsp_valid, rsp_id, rsp_nv, rsp_nx, rsp_tag}, 64'd0);
        check("reset_rsp_int", rsp_int, 64'd0);
        check("reset_ready", {62'd0, req1_ready, req0_ready}, 64'd0);

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

        // Round robin from reset with both requesters permanently valid
        do_reset();
        req0_fp = 64'h3FF0000000000000; req0_tag = 4'd1;
        req1_fp = 64'h4000000000000000; req1_tag = 4'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rsp_valid) begin
                check($sformatf("rr%0d_id", got), {63'd0, rsp_id}, 64'(got % 2));
                check($sformatf("rr%0d_tag", got), {60'd0, rsp_tag}, (got % 2) ? 64'd2 : 64'd1);
                check($sformatf("rr%0d_int", got), rsp_int, (got % 2) ? 64'd2 : 64'd1);
                got++;
            end
        end
        check("rr_count", 64'(got), 64'd4);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (4) @(posedge clk);

        // Back-pressure: response must stay frozen and no one is granted
        do_reset();
        hv = '{1'b0, 64'hBFF8000000000000, 4'h6, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1};
        req0_valid = 1'b1; req0_fp = hv.fp; req0_tag = hv.tag;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_fp = 64'h4000000000000000; req1_tag = 4'h2;
        @(posedge clk);
        #1;
        checkOutput("hold_first", hv);
        snap_int  = rsp_int;
        snap_misc = {rsp_valid, rsp_id, rsp_nv, rsp_nx, rsp_tag};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_int", k), rsp_int, snap_int);
            check($sformatf("hold%0d_misc", k), {56'd0, rsp_valid, rsp_id, rsp_nv, rsp_nx, rsp_tag},
                  {56'd0, snap_misc});
            check($sformatf("hold%0d_ready", k), {62'd0, req1_ready, req0_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("hold_release_valid", {63'd0, rsp_valid}, 64'd0);
        check("hold_release_idle", {62'd0, req1_ready, req0_ready}, 64'd2);
        req1_valid = 1'b0;
        @(negedge clk);

        // Reset during CONV after req0 was granted last
        do_reset();
        req0_valid = 1'b1; req0_fp = 64'h4059000000000000; req0_tag = 4'h3;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_conv_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_conv_int", rsp_int, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (rsp_valid) saw = 1'b1;
        end
        check("rst_no_response", {63'd0, saw}, 64'd0);
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_tie_grant", {62'd0, req1_ready, req0_ready}, 64'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fcvt_arb.md
FCVT_ARB -- requirements
Module: fcvt_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning the width of the opaque per-request tag returned with each result.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  the reset, asynchronous and active-low.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has a double-precision operand to convert.
REQ-005 SHALL have port req0_fp  input  64  requester 0 operand, IEEE-754 binary64.
REQ-006 SHALL have port req0_tag  input  TAG_W  requester 0 tag.
REQ-007 SHALL have port req0_ready  output  1  requester 0 operand accepted this cycle when req0_valid is also high.
REQ-008 SHALL have ports req1_valid, req1_fp, req1_tag and req1_ready, identical to requester 0 in direction, width and meaning.
REQ-009 SHALL have port rsp_valid  output  1  result registers hold a valid conversion.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-012 SHALL have port rsp_tag  output  TAG_W  tag of the owning request.
REQ-013 SHALL have port rsp_int  output  64  signed int64 result.
REQ-014 SHALL have port rsp_nv  output  1  invalid-operation flag.
REQ-015 SHALL have port rsp_nx  output  1  inexact flag.

Function
REQ-016 SHALL instantiate exactly one FCVT_int (ports fp, in) and share it between both requesters; rsp_int SHALL be its output, unmodified: truncation toward zero, saturation to 0x7FFFFFFFFFFFFFFF / 0x8000000000000000.
REQ-017 SHALL implement FSM IDLE -> CONV -> HOLD -> IDLE; no other states.
REQ-018 SHALL, in IDLE only, assert reqN_ready combinationally for the granted requester and no other; both readys SHALL be 0 in CONV and HOLD.
REQ-019 SHALL grant, in IDLE, the sole valid requester, or when both are valid the one not granted last (round-robin pointer updated on each accept).
REQ-020 SHALL, on an accept (valid & ready), capture operand, tag and requester index into internal registers and move to CONV.
REQ-021 SHALL, in CONV, drive the captured operand into FCVT_int, register rsp_int, rsp_nv, rsp_nx, rsp_tag and rsp_id, set rsp_valid and move to HOLD.
REQ-022 SHALL, in HOLD, hold all rsp_* outputs stable while rsp_ready is low, and on rsp_ready high clear rsp_valid and return to IDLE on that edge.
REQ-023 SHALL have a latency of accept edge N to rsp_valid high after edge N+1, and a best-case throughput of one conversion per 3 cycles.
REQ-024 SHALL set rsp_nv when the exponent field is 2047 (Inf or NaN), or when the exponent field is >= 1086 and the operand is not exactly 0xC3E0000000000000.
REQ-025 SHALL set rsp_nx when rsp_nv is 0, the operand is nonzero and not integral: exponent field < 1023 with a nonzero exponent or mantissa, or 1023 <= exponent < 1075 with any of the low (1075-exponent) mantissa bits nonzero.
REQ-026 SHALL treat ±0.0 and subnormals: ±0.0 gives nx=0; subnormals give nx=1; both give int 0 and nv=0.
REQ-027 SHALL ignore reqN_fp and reqN_tag whenever reqN_ready is low; a requester dropping valid before acceptance SHALL not be granted.

Reset
REQ-028 SHALL, on rst_n low, immediately clear state to IDLE, rsp_valid, rsp_id, rsp_tag, rsp_int, rsp_nv and rsp_nx to 0, and the round-robin pointer to 1, so requester 0 wins the first tie.
REQ-029 SHALL discard any in-flight (CONV or HOLD) conversion on reset with no response produced.

Verification
REQ-030 SHALL verify that req0 alone with 0x3FF0000000000000 and rsp_ready=1 gives rsp_valid 2 edges after accept, with int 1, nv=0, nx=0, id=0.
REQ-031 SHALL verify that req1 with 0xBFF8000000000000 gives int -1, nx=1, nv=0, id=1.
REQ-032 SHALL verify that 0x47F0000000000000 gives int 0x7FFFFFFFFFFFFFFF with nv=1, and 0xC3E0000000000000 gives 0x8000000000000000 with nv=0, nx=0.
REQ-033 SHALL verify that both requesters valid continuously out of reset, with tags 1 and 2, are served in the order req0, req1, req0, req1, each with the matching rsp_tag.
REQ-034 SHALL verify that holding rsp_ready=0 for 5 cycles in HOLD keeps rsp_* stable and both readys 0, and that a single rsp_ready pulse then returns the FSM to IDLE.
REQ-035 SHALL verify that asserting rst_n low during CONV gives rsp_valid=0 immediately, no response after release, and a first tie after release granted to req0.
